shift_rows_pipe: RTL
====================

# shift_rows_pipe

- Parametrised, pipelined ShiftRows / InvShiftRows stage for the round datapath.
- Supports Rijndael block widths of 4, 6 or 8 columns.
- Direction is selected per beat, and a tag is carried alongside each beat.
- Sits between SubBytes and MixColumns, connected by valid/ready handshakes on both sides.
- A two-entry skid buffer gives full throughput under downstream back-pressure.

## Interface
- `NB`, default 4: number of 32-bit state columns. Legal values are 4, 6, 8; any other value is an elaboration error.
- `TAG_W`, default 4: width of the sideband tag (round number or key-slot ID). Must be ≥ 1.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: input beat present.
- `in_ready`, output, 1: stage can accept a beat.
- `in_inv`, input, 1: 0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt).
- `in_tag`, input, TAG_W: sideband, passed through unchanged.
- `in_state`, input, 32*NB: state. Column c is `in_state[32*(NB-c)-1 -: 32]` (column 0 most significant). Row r of a column is bits `[31-8r -: 8]`.
- `out_valid`, output, 1: output beat present.
- `out_ready`, input, 1: downstream accepts.
- `out_tag`, output, TAG_W: tag of the presented beat.
- `out_state`, output, 32*NB: shifted state, same layout as `in_state`.

## Operation
- Row offsets s(r) for rows 0..3:
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Forward permutation: `out[r][c] = in[r][(c + s(r)) mod NB]`.
- Inverse permutation: `out[r][c] = in[r][(c − s(r) + NB) mod NB]`.
- The index modulo is resolved at elaboration; the datapath is pure byte routing plus one 2:1 mux per byte selected by `in_inv`.
- The permutation is computed on the input side. The registers hold already-shifted state, tag and valid.
- Storage is a main register M, which drives the outputs, and a skid register S.
- FSM with three states:
  - **EMPTY**: M and S both invalid.
  - **ONE**: M valid, S invalid.
  - **FULL**: M and S both valid.
- Transitions (acc = `in_valid & in_ready`, pop = `out_valid & out_ready`):
  - EMPTY, acc → ONE; the beat loads M.
  - ONE, acc & pop → ONE; M is reloaded with the new beat.
  - ONE, acc & !pop → FULL; the beat loads S.
  - ONE, !acc & pop → EMPTY.
  - FULL, pop → ONE; S moves to M. There is no accept in FULL.
  - Any other combination holds the current state.
- `in_ready` = (state != FULL) & !rst. It is a registered-state decode with no combinational path from `out_ready`.
- Beats leave in acceptance order. Tag and `in_inv` stay bound to their own beat.
- Reset asserted mid-operation discards M and S immediately. Beats accepted before reset are never emitted.

## Timing
- Latency: a beat accepted at edge N is presented with `out_valid`=1 after edge N (cycle N+1). No combinational in→out path.
- Throughput: 1 beat/cycle while `out_ready`=1.
- While `out_valid` & !`out_ready`: `out_state` and `out_tag` are held stable.
- After one stalled beat is absorbed, `in_ready` deasserts the cycle after the FULL transition.
- `in_ready` reasserts the cycle after the first pop in FULL.
- Reset values while `rst`=1:
  - `out_valid`=0, `out_state`=0, `out_tag`=0.
  - `in_ready`=0.
  - FSM = EMPTY.
- The first accept is possible on the first edge after `rst` deasserts.
- Inputs other than `in_valid` are don't-care when `in_valid`=0.

## Configuration
- `SHIFT_ROWS_PARITY_EN` defined, extra ports:
  - `in_par` (input, 4*NB): even parity per byte, bit index = byte index.
  - `out_par` (output, 4*NB): parity permuted identically to the data and registered with it.
  - `par_err` (output, 1): sticky; set on the edge that accepts a beat whose recomputed byte parity mismatches `in_par`; cleared only by `rst`; reset value 0.
- `SHIFT_ROWS_PARITY_EN` undefined: none of these ports exist, and no parity logic is present.

## Test plan
- **NB=4 forward:** `in_state`=0xd42711ae_e0bf98f1_b8b45de5_1e415230, `in_inv`=0, `out_ready`=1 → next cycle `out_state`=0xd4bf5d30_e0b452ae_b84111f1_1e2798e5, tag preserved.
- **NB=4 inverse:** `in_state`=0xd4bf5d30_e0b452ae_b84111f1_1e2798e5, `in_inv`=1 → `out_state`=0xd42711ae_e0bf98f1_b8b45de5_1e415230.
- **NB=8 forward:** byte value `in[r][c]` = 0x(r)(c) → output column 0 rows 0..3 = 0x00, 0x11, 0x23, 0x34; column 7 = 0x07, 0x10, 0x22, 0x33.
- **Back-pressure:** stream tags 1..6, `out_ready` low for cycles 3–5 → `in_ready` low from the cycle after FULL; output tag sequence is exactly 1..6 with no drop or duplicate; held outputs stable.
- **Mixed mode / reset:** alternate `in_inv` per beat, each output matches its own mode. Assert `rst` while FULL → `out_valid`=0 and `in_ready`=0 immediately; neither held beat appears after release.
- **Parity (macro on):** flip `in_par[5]` on one beat → `par_err`=1 after that edge and stays 1 until `rst`; `out_par` matches the permuted parity of clean beats.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: pipelined ShiftRows / InvShiftRows stage for NB = 4, 6 or 8
// columns, with valid/ready handshakes on both sides and a two-entry skid
// buffer. Each beat carries its own direction bit and sideband tag.
//
// Optional feature macro: SHIFT_ROWS_PARITY_EN
//   When defined, per-byte even parity travels with the data (in_par/out_par)
//   and a sticky par_err flags any accepted beat whose parity mismatches.
//
// State layout: column c is bits [32*(NB-c)-1 -: 32] (column 0 is the most
// significant), row r of a column is bits [31-8r -: 8]. Parity bit k covers
// data bits [8k+7 : 8k].
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [32*NB-1:0]  in_state,
`ifdef SHIFT_ROWS_PARITY_EN
  input  logic [4*NB-1:0]   in_par,
  output logic [4*NB-1:0]   out_par,
  output logic              par_err,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [32*NB-1:0]  out_state
);

  // ------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ------------------------------------------------------------------
  if (!((NB == 4) || (NB == 6) || (NB == 8))) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_rows_pipe: TAG_W must be at least 1");
  end

  // Row rotation amount; the 256-bit block uses a wider spread on rows 2/3.
  function automatic int row_off(input int r);
    int off;
    off = 32'sd0;
    if (NB == 8) begin
      case (r)
        0:       off = 32'sd0;
        1:       off = 32'sd1;
        2:       off = 32'sd3;
        3:       off = 32'sd4;
        default: off = 32'sd0;
      endcase
    end else begin
      off = r;
    end
    return off;
  endfunction

`ifdef SHIFT_ROWS_PARITY_EN
  // Even parity of every byte of a state word; bit k covers byte k.
  function automatic logic [4*NB-1:0] byte_parity(input logic [32*NB-1:0] d);
    logic [4*NB-1:0] p;
    p = '0;
    for (int k = 0; k < 4*NB; k++) begin
      p[k] = ^d[8*k +: 8];
    end
    return p;
  endfunction
`endif

  // ------------------------------------------------------------------
  // Byte routing: both permutations are fixed wiring, one 2:1 mux per byte
  // ------------------------------------------------------------------
  logic [32*NB-1:0] shifted_s;
`ifdef SHIFT_ROWS_PARITY_EN
  logic [4*NB-1:0]  shifted_par_s;
`endif

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int OFF   = row_off(r);
      localparam int FWD_C = (c + OFF) % NB;
      localparam int INV_C = (c + NB - OFF) % NB;
      localparam int DST_H = 32*(NB-c) - 1 - 8*r;
      localparam int FWD_H = 32*(NB-FWD_C) - 1 - 8*r;
      localparam int INV_H = 32*(NB-INV_C) - 1 - 8*r;
      assign shifted_s[DST_H -: 8] = in_inv ? in_state[INV_H -: 8]
                                            : in_state[FWD_H -: 8];
`ifdef SHIFT_ROWS_PARITY_EN
      localparam int DST_P = 4*(NB-c) - 1 - r;
      localparam int FWD_P = 4*(NB-FWD_C) - 1 - r;
      localparam int INV_P = 4*(NB-INV_C) - 1 - r;
      assign shifted_par_s[DST_P] = in_inv ? in_par[INV_P] : in_par[FWD_P];
`endif
    end
  end

  // ------------------------------------------------------------------
  // Occupancy FSM
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_r;
  state_t state_s;
  logic   acc_s;
  logic   pop_s;
  logic   load_m_in_s;
  logic   load_skid_s;
  logic   skid_to_m_s;

  // Ready is a pure decode of the registered state, gated low during reset.
  assign in_ready  = (state_r != ST_FULL) & ~rst;
  assign out_valid = (state_r != ST_EMPTY);
  assign acc_s     = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and register-load decode.
  always_comb begin
    state_s     = state_r;
    load_m_in_s = 1'b0;
    load_skid_s = 1'b0;
    skid_to_m_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (acc_s) begin
          state_s     = ST_ONE;
          load_m_in_s = 1'b1;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (acc_s && pop_s) begin
          state_s     = ST_ONE;
          load_m_in_s = 1'b1;
        end else if (acc_s) begin
          state_s     = ST_FULL;
          load_skid_s = 1'b1;
        end else if (pop_s) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_ONE;
        end
      end
      ST_FULL: begin
        if (pop_s) begin
          state_s     = ST_ONE;
          skid_to_m_s = 1'b1;
        end else begin
          state_s = ST_FULL;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Storage: main register M drives the outputs, S absorbs one stalled beat
  // ------------------------------------------------------------------
  logic [32*NB-1:0] m_state_r;
  logic [TAG_W-1:0] m_tag_r;
  logic [32*NB-1:0] s_state_r;
  logic [TAG_W-1:0] s_tag_r;

  // Main register: new beat from the input side, or promotion from skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state_r <= '0;
      m_tag_r   <= '0;
    end else if (load_m_in_s) begin
      m_state_r <= shifted_s;
      m_tag_r   <= in_tag;
    end else if (skid_to_m_s) begin
      m_state_r <= s_state_r;
      m_tag_r   <= s_tag_r;
    end
  end

  // Skid register: captures the beat accepted while M is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_state_r <= '0;
      s_tag_r   <= '0;
    end else if (load_skid_s) begin
      s_state_r <= shifted_s;
      s_tag_r   <= in_tag;
    end
  end

  assign out_state = m_state_r;
  assign out_tag   = m_tag_r;

`ifdef SHIFT_ROWS_PARITY_EN
  logic [4*NB-1:0] m_par_r;
  logic [4*NB-1:0] s_par_r;
  logic            par_err_r;
  logic            par_bad_s;

  assign par_bad_s = (byte_parity(in_state) != in_par);

  // Parity side of the main register, moving in lockstep with the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_par_r <= '0;
    end else if (load_m_in_s) begin
      m_par_r <= shifted_par_s;
    end else if (skid_to_m_s) begin
      m_par_r <= s_par_r;
    end
  end

  // Parity side of the skid register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_par_r <= '0;
    end else if (load_skid_s) begin
      s_par_r <= shifted_par_s;
    end
  end

  // Sticky error: set by any accepted beat with bad parity, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_r <= 1'b0;
    end else if (acc_s && par_bad_s) begin
      par_err_r <= 1'b1;
    end
  end

  assign out_par = m_par_r;
  assign par_err = par_err_r;
`endif

endmodule
